// File: rtl/branch_ctrl_if.sv
// Issue and fetch-redirect bundle between the EX stage and branch_ctrl.
// The slave side belongs to branch_ctrl; the master side drives it.
interface branch_ctrl_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc;
    logic [31:0] i_imm;
    logic [31:0] i_r1;
    logic [31:0] i_r2;
    logic [2:0]  i_func3;
    logic        i_is_jal;
    logic        i_is_jalr;
    logic        i_pred_taken;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        i_redirect_ready;

    modport slave (
        input  i_valid,
        output o_ready,
        input  i_pc,
        input  i_imm,
        input  i_r1,
        input  i_r2,
        input  i_func3,
        input  i_is_jal,
        input  i_is_jalr,
        input  i_pred_taken,
        output o_redirect_valid,
        output o_redirect_pc,
        input  i_redirect_ready
    );

    modport master (
        output i_valid,
        input  o_ready,
        output i_pc,
        output i_imm,
        output i_r1,
        output i_r2,
        output i_func3,
        output i_is_jal,
        output i_is_jalr,
        output i_pred_taken,
        input  o_redirect_valid,
        input  o_redirect_pc,
        output i_redirect_ready
    );
endinterface

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution, fetch redirect/flush sequencing, mispredict count.
// Optional BRANCH_PREDICT_EN adds a 16-entry 2-bit predictor table.
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    branch_ctrl_if.slave bus,
    input  logic [31:0]  i_fetch_pc,
    output logic         o_flush,
    output logic         o_misalign,
    output logic         o_pred_taken,
    output logic [15:0]  o_mispredict_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        REDIRECT,
        FLUSH
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic [31:0] r1_q;
    logic [31:0] r2_q;
    logic [2:0]  func3_q;
    logic        jal_q;
    logic        jalr_q;
    logic        pred_q;

    logic [31:0] redirect_pc_q;
    logic [3:0]  flush_cnt_q;
    logic [15:0] mispredict_cnt;

    logic        accept;
    logic        in_resolve;
    logic        handshake;
    logic        taken;
    logic        misalign;
    logic        mispredict;
    logic        go_redirect;
    logic [31:0] seq_pc;
    logic [31:0] br_target;
    logic [31:0] jalr_sum;
    logic [31:0] target;
    logic        unused_fetch;

    assign accept     = bus.i_valid && (state_q == IDLE);
    assign in_resolve = (state_q == RESOLVE);
    assign handshake  = (state_q == REDIRECT) && bus.i_redirect_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q    <= '0;
            imm_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            func3_q <= '0;
            jal_q   <= 1'b0;
            jalr_q  <= 1'b0;
            pred_q  <= 1'b0;
        end else if (accept) begin
            pc_q    <= bus.i_pc;
            imm_q   <= bus.i_imm;
            r1_q    <= bus.i_r1;
            r2_q    <= bus.i_r2;
            func3_q <= bus.i_func3;
            jal_q   <= bus.i_is_jal;
            jalr_q  <= bus.i_is_jalr;
            pred_q  <= bus.i_pred_taken;
        end
    end

    always_comb begin
        taken = 1'b0;
        if (jal_q || jalr_q) begin
            taken = 1'b1;
        end else begin
            case (func3_q)
                3'b000:  taken = (r1_q == r2_q);
                3'b001:  taken = (r1_q != r2_q);
                3'b100:  taken = ($signed(r1_q) < $signed(r2_q));
                3'b101:  taken = ($signed(r1_q) >= $signed(r2_q));
                3'b110:  taken = (r1_q < r2_q);
                3'b111:  taken = (r1_q >= r2_q);
                default: taken = 1'b0;
            endcase
        end
    end

    assign seq_pc    = pc_q + 32'd4;
    assign br_target = pc_q + imm_q;
    assign jalr_sum  = r1_q + imm_q;
    assign target    = jalr_q ? {jalr_sum[31:1], 1'b0} : br_target;

    assign misalign    = taken && (target[1:0] != 2'b00);
    assign mispredict  = (taken != pred_q) || (jalr_q && taken);
    assign go_redirect = in_resolve && !misalign && mispredict;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) state_d = RESOLVE;
            end
            RESOLVE: begin
                if (go_redirect) state_d = REDIRECT;
                else             state_d = IDLE;
            end
            REDIRECT: begin
                if (bus.i_redirect_ready) state_d = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt_q <= 4'd1) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Target is captured once so it stays stable while fetch stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_pc_q <= '0;
        end else if (go_redirect) begin
            redirect_pc_q <= taken ? target : seq_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flush_cnt_q <= '0;
        end else if (handshake) begin
            flush_cnt_q <= FLUSH_LOAD;
        end else if ((state_q == FLUSH) && (flush_cnt_q != 4'd0)) begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mispredict_cnt <= '0;
        end else if (go_redirect && (mispredict_cnt != 16'hFFFF)) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

    assign bus.o_ready          = (state_q == IDLE);
    assign bus.o_redirect_valid = (state_q == REDIRECT);
    assign bus.o_redirect_pc    = redirect_pc_q;
    assign o_flush              = (state_q == FLUSH);
    assign o_misalign           = in_resolve && misalign;
    assign o_mispredict_cnt     = mispredict_cnt;

    assign unused_fetch = ^i_fetch_pc;

`ifdef BRANCH_PREDICT_EN
    logic [1:0] bht_q [16];
    logic [3:0] upd_idx;
    logic       bht_upd;

    assign upd_idx = pc_q[5:2];
    assign bht_upd = in_resolve && !jal_q && !jalr_q && !misalign;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) bht_q[i] <= 2'b01;
        end else if (bht_upd) begin
            if (taken && (bht_q[upd_idx] != 2'b11))
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            else if (!taken && (bht_q[upd_idx] != 2'b00))
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
        end
    end

    assign o_pred_taken = bht_q[i_fetch_pc[5:2]][1];
`else
    assign o_pred_taken = 1'b0;
`endif

endmodule
